// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline <-> hazard controller signal bundle
// Perf counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_controller_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic       ex_branch_taken;
  logic       ex_md_start;
  logic       md_done;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       ex_hold;
  logic       ex_mem_bubble;
  logic       md_timeout_err;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, ex_md_start, md_done,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold,
           ex_mem_bubble, md_timeout_err, state
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, ex_md_start, md_done,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold,
           ex_mem_bubble, md_timeout_err, state
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / branch / mul-div hazard controller
// Optional stall/flush counters enabled by HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int MD_TIMEOUT = 34
) (
  input logic           clk,
  input logic           rst_n,
  hazard_controller_if.slave hif
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01,
    ERR     = 2'b10
  } state_e;

  localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use;

  assign load_use = hif.id_ex_mem_read && (hif.id_ex_rd != 5'd0) &&
                    ((hif.id_uses_rs1 && (hif.id_rs1 == hif.id_ex_rd)) ||
                     (hif.id_uses_rs2 && (hif.id_rs2 == hif.id_ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (hif.ex_md_start && !hif.md_done) begin
          state_d = MD_WAIT;
          cnt_d   = 6'd0;
        end
      end
      MD_WAIT: begin
        // Completion beats the timeout when both land in the same cycle.
        if (hif.md_done) begin
          state_d = RUN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    hif.pc_write       = 1'b1;
    hif.if_id_write    = 1'b1;
    hif.id_ex_bubble   = 1'b0;
    hif.if_id_flush    = 1'b0;
    hif.ex_hold        = 1'b0;
    hif.ex_mem_bubble  = 1'b0;
    hif.md_timeout_err = 1'b0;
    hif.state          = RUN;
    if (rst_n) begin
      hif.state = state_q;
      unique case (state_q)
        RUN: begin
          if (hif.ex_branch_taken) begin
            hif.if_id_flush  = 1'b1;
            hif.id_ex_bubble = 1'b1;
          end else if (load_use) begin
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.id_ex_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!hif.md_done) begin
            hif.pc_write      = 1'b0;
            hif.if_id_write   = 1'b0;
            hif.ex_hold       = 1'b1;
            hif.ex_mem_bubble = 1'b1;
          end else if (load_use) begin
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.id_ex_bubble = 1'b1;
          end
        end
        default: begin
          hif.pc_write       = 1'b0;
          hif.if_id_write    = 1'b0;
          hif.ex_hold        = 1'b1;
          hif.ex_mem_bubble  = 1'b1;
          hif.md_timeout_err = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!hif.pc_write && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (hif.if_id_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed checks of hazard_controller
// Two instances: default timeout and MD_TIMEOUT=4.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_controller_if hif ();
  hazard_controller_if hif4 ();

  assign hif4.id_rs1          = hif.id_rs1;
  assign hif4.id_rs2          = hif.id_rs2;
  assign hif4.id_uses_rs1     = hif.id_uses_rs1;
  assign hif4.id_uses_rs2     = hif.id_uses_rs2;
  assign hif4.id_ex_mem_read  = hif.id_ex_mem_read;
  assign hif4.id_ex_rd        = hif.id_ex_rd;
  assign hif4.ex_branch_taken = hif.ex_branch_taken;
  assign hif4.ex_md_start     = hif.ex_md_start;
  assign hif4.md_done         = hif.md_done;

  hazard_controller u_dut (.clk(clk), .rst_n(rst_n), .hif(hif.slave));
  hazard_controller #(.MD_TIMEOUT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .hif(hif4.slave));

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble, err, state}
  logic [8:0] o, o4;
  assign o  = {hif.pc_write, hif.if_id_write, hif.id_ex_bubble, hif.if_id_flush,
               hif.ex_hold, hif.ex_mem_bubble, hif.md_timeout_err, hif.state};
  assign o4 = {hif4.pc_write, hif4.if_id_write, hif4.id_ex_bubble, hif4.if_id_flush,
               hif4.ex_hold, hif4.ex_mem_bubble, hif4.md_timeout_err, hif4.state};

  localparam logic [8:0] RUN_N   = 9'b1_1_0_0_0_0_0_00;
  localparam logic [8:0] STALL   = 9'b0_0_1_0_0_0_0_00;
  localparam logic [8:0] BRANCH  = 9'b1_1_1_1_0_0_0_00;
  localparam logic [8:0] HOLD    = 9'b0_0_0_0_1_1_0_01;
  localparam logic [8:0] MD_FIN  = 9'b1_1_0_0_0_0_0_01;
  localparam logic [8:0] ERR_OUT = 9'b0_0_0_0_1_1_1_10;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0;
    hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.id_ex_mem_read = 1'b0; hif.id_ex_rd = 5'd0;
    hif.ex_branch_taken = 1'b0; hif.ex_md_start = 1'b0; hif.md_done = 1'b0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    // Reset with hazard-triggering inputs: must still decode as RUN
    rst_n = 1'b0;
    idle();
    hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 5'd5; hif.id_rs1 = 5'd5;
    hif.id_uses_rs1 = 1'b1; hif.ex_branch_taken = 1'b1;
    @(negedge clk); #1;
    chk("reset_decode", o, RUN_N);
    next(); rst_n = 1'b1; idle(); #1;
    chk("after_reset", o, RUN_N);

    next(); hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 5'd5; hif.id_rs1 = 5'd5;
    hif.id_uses_rs1 = 1'b1; #1;
    chk("load_use_rs1", o, STALL);
    next(); idle(); #1;
    chk("load_use_next", o, RUN_N);

    next(); hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 5'd0; hif.id_rs1 = 5'd0;
    hif.id_uses_rs1 = 1'b1; #1;
    chk("x0_no_stall", o, RUN_N);
    next(); idle(); hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 5'd5; hif.id_rs2 = 5'd5; #1;
    chk("unused_rs2", o, RUN_N);
    hif.id_uses_rs2 = 1'b1; #1;
    chk("load_use_rs2", o, STALL);
    hif.id_ex_mem_read = 1'b0; #1;
    chk("no_load_no_stall", o, RUN_N);

    next(); idle(); hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 5'd7; hif.id_rs1 = 5'd7;
    hif.id_uses_rs1 = 1'b1; hif.ex_branch_taken = 1'b1; #1;
    chk("branch_over_load_use", o, BRANCH);

    // Mul/div with 4 wait cycles on the default-timeout instance
    next(); idle(); hif.ex_md_start = 1'b1; #1;
    chk("md_start_cycle", o, RUN_N);
    for (int i = 0; i < 4; i++) begin
      next(); idle(); hif.ex_branch_taken = (i == 1); hif.ex_md_start = (i == 2); #1;
      chk($sformatf("md_wait_%0d", i), o, HOLD);
    end
    next(); idle(); hif.md_done = 1'b1; #1;
    chk("md_done_cycle", o, MD_FIN);
    next(); idle(); #1;
    chk("md_back_run", o, RUN_N);

    next(); hif.ex_md_start = 1'b1; hif.md_done = 1'b1; #1;
    chk("md_single_cycle", o, RUN_N);
    next(); idle(); #1;
    chk("md_single_stays_run", o, RUN_N);

    // Timeout on the MD_TIMEOUT=4 instance
    rst_n = 1'b0;
    next(); rst_n = 1'b1; idle(); hif.ex_md_start = 1'b1; #1;
    chk("to_start", o4, RUN_N);
    for (int i = 0; i < 4; i++) begin
      next(); idle(); #1;
      chk($sformatf("to_wait_%0d", i), o4, HOLD);
    end
    next(); #1;
    chk("to_err", o4, ERR_OUT);
    next(); hif.md_done = 1'b1; hif.ex_md_start = 1'b1; #1;
    chk("err_sticky", o4, ERR_OUT);
    next(); idle(); rst_n = 1'b0; #1;
    chk("err_reset_decode", o4, RUN_N);
    next(); rst_n = 1'b1; #1;
    chk("err_cleared", o4, RUN_N);

    // md_done coinciding with the timeout cycle returns to RUN
    next(); hif.ex_md_start = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      next(); idle(); #1;
      chk($sformatf("race_wait_%0d", i), o4, HOLD);
    end
    next(); hif.md_done = 1'b1; #1;
    chk("race_done", o4, MD_FIN);
    next(); idle(); #1;
    chk("race_run", o4, RUN_N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
